// File: rtl/div_nr_sched.sv
// div_nr_sched: one 8/4 nonrestoring divider shared by NREQ requesters.
//   Requests are granted round-robin in IDLE only. Each accepted operation is
//   either screened out (divide-by-zero or a quotient that needs more than 4
//   bits) and answered the next cycle, or iterated one quotient bit per clock.
//   The response is tagged with the id of the requester that was granted.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  [NREQ]    per-requester operation pending
//   req_a      [8*NREQ]  dividends, requester i at [8i+7:8i]
//   req_b      [4*NREQ]  divisors,  requester i at [4i+3:4i]
//   req_ready  [NREQ]    one-hot grant (combinational, IDLE only)
//   rsp_valid            response held until rsp_ready
//   rsp_ready            consumer accepts the response
//   rsp_id     [IDW]     requester being answered
//   rslt       [8]       {remainder, quotient}; 8'h00 on error
//   err                  divide-by-zero or quotient overflow
module div_nr_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [4*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rslt,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;     // requester with top priority
  logic [1:0]     cnt;     // iteration index 0..3
  logic [5:0]     r;       // signed partial remainder
  logic [3:0]     q;       // dividend low bits shifting out, quotient shifting in
  logic [3:0]     bq;      // latched divisor

  // Flat request buses viewed as per-requester lanes.
  logic [NREQ-1:0][7:0] a_arr;
  logic [NREQ-1:0][3:0] b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  // ---------------- round-robin arbiter ----------------
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic [IDW-1:0]  cand;
  logic            hit;

  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    hit   = 1'b0;
    // Scan starting at the pointer and wrap; first valid requester wins.
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!hit && req_valid[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        hit         = 1'b1;
      end
    end
  end

  // Gating with rst_n keeps the grant low while reset is being held.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;

  logic            acc;
  logic [7:0]      a_sel;
  logic [3:0]      b_sel;
  logic            bad;
  logic [IDW-1:0]  ptr_nxt;

  assign acc     = |(req_valid & req_ready);
  assign a_sel   = a_arr[gidx];
  assign b_sel   = b_arr[gidx];
  // b == 0 is caught by the compare as well, listed for clarity.
  assign bad     = (b_sel == 4'd0) || (a_sel[7:4] >= b_sel);
  assign ptr_nxt = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  // ---------------- nonrestoring step ----------------
  logic [5:0] r_sh;
  logic [5:0] r_nxt;
  logic [3:0] rem;

  // Shift in the next dividend bit, then add or subtract depending on sign.
  assign r_sh  = {r[4:0], q[3]};
  assign r_nxt = r[5] ? (r_sh + {2'b00, bq}) : (r_sh - {2'b00, bq});
  // Final correction; the true remainder lies in [0,b) so 4 bits suffice.
  assign rem   = r[5] ? (r[3:0] + bq) : r[3:0];

  // ---------------- control / datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      bq        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rslt      <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            ptr    <= ptr_nxt;
            rsp_id <= gidx;
            bq     <= b_sel;
            r      <= {2'b00, a_sel[7:4]};
            q      <= a_sel[3:0];
            cnt    <= '0;
            if (bad) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              err       <= 1'b1;
              rslt      <= 8'h00;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          r   <= r_nxt;
          q   <= {q[2:0], ~r_nxt[5]};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= FIX;
        end
        FIX: begin
          rslt      <= {rem, q};
          err       <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nr_sched.sv
module tb_div_nr_sched;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_a;
  logic [4*NREQ-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [7:0]          rslt;
  logic                err;

  int npass = 0;
  int ntot  = 0;

  div_nr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rslt(rslt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [3:0] b);
    req_a[8*i +: 8] = a;
    req_b[4*i +: 4] = b;
  endtask

  // Called at a negedge with inputs already set. Checks the grant, lets it be
  // accepted, measures latency to rsp_valid, checks the response and that no
  // grant was offered while busy, then completes the handshake (rsp_ready=1).
  task automatic run(input string tag, input logic [1:0] gnt, input logic id,
                     input logic [7:0] exp_r, input logic exp_e,
                     input int exp_lat, input bit clr);
    int   lat;
    logic busy_rdy;
    #1;
    chk({tag, " gnt"}, 32'(req_ready), 32'(gnt));
    @(posedge clk);
    @(negedge clk);
    busy_rdy = |req_ready;
    if (clr) req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      busy_rdy = busy_rdy | (|req_ready);
    end
    chk({tag, " lat"},  32'(lat), 32'(exp_lat));
    chk({tag, " id"},   32'(rsp_id), 32'(id));
    chk({tag, " rslt"}, 32'(rslt), 32'(exp_r));
    chk({tag, " err"},  32'(err), 32'(exp_e));
    chk({tag, " busy_rdy"}, 32'(busy_rdy), 32'(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " drop"}, 32'(rsp_valid), 32'(1'b0));
  endtask

  initial begin
    int   lat;
    logic stable;
    logic seen;

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'(2'b00));
    chk("rst rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("rst rsp_id",    32'(rsp_id), 32'(1'b0));
    chk("rst rslt",      32'(rslt), 32'(8'h00));
    chk("rst err",       32'(err), 32'(1'b0));

    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // 7/3 = 2 r1 through requester 0
    set_req(0, 8'h07, 4'h3); req_valid = 2'b01;
    run("t0_7_3", 2'b01, 1'b0, 8'b0001_0010, 1'b0, 6, 1'b1);

    // Directed vectors through requester 1
    set_req(1, 8'h3C, 4'h7); req_valid = 2'b10;
    run("v_3c_7", 2'b10, 1'b1, 8'b0100_1000, 1'b0, 6, 1'b1);
    set_req(1, 8'h52, 4'h6); req_valid = 2'b10;
    run("v_52_6", 2'b10, 1'b1, 8'b0100_1101, 1'b0, 6, 1'b1);
    set_req(1, 8'h64, 4'h7); req_valid = 2'b10;
    run("v_64_7", 2'b10, 1'b1, 8'b0010_1110, 1'b0, 6, 1'b1);
    set_req(1, 8'h6E, 4'h7); req_valid = 2'b10;
    run("v_6e_7", 2'b10, 1'b1, 8'b0101_1111, 1'b0, 6, 1'b1);

    // Error screen: overflow then divide-by-zero, both answered at T+1
    set_req(0, 8'h80, 4'h3); req_valid = 2'b01;
    run("ovf", 2'b01, 1'b0, 8'h00, 1'b1, 1, 1'b1);
    set_req(1, 8'h15, 4'h0); req_valid = 2'b10;
    run("dz", 2'b10, 1'b1, 8'h00, 1'b1, 1, 1'b1);

    // Fairness: both held valid, pointer is back at 0
    set_req(0, 8'h3C, 4'h7);
    set_req(1, 8'h64, 4'h7);
    req_valid = 2'b11;
    run("fair0", 2'b01, 1'b0, 8'b0100_1000, 1'b0, 6, 1'b0);
    run("fair1", 2'b10, 1'b1, 8'b0010_1110, 1'b0, 6, 1'b0);
    run("fair2", 2'b01, 1'b0, 8'b0100_1000, 1'b0, 6, 1'b0);
    run("fair3", 2'b10, 1'b1, 8'b0010_1110, 1'b0, 6, 1'b0);

    // Back-pressure: response must hold while rsp_ready is low
    set_req(0, 8'h52, 4'h6);
    rsp_ready = 1'b0;
    #1;
    chk("stall gnt", 32'(req_ready), 32'(2'b01));
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("stall lat",  32'(lat), 32'(6));
    chk("stall rslt", 32'(rslt), 32'(8'b0100_1101));
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(rsp_valid === 1'b1 && rslt === 8'b0100_1101 && rsp_id === 1'b0 &&
            err === 1'b0 && req_ready === 2'b00)) stable = 1'b0;
    end
    chk("stall hold", 32'(stable), 32'(1'b1));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall release rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("stall next grant", 32'(req_ready), 32'(2'b10));
    run("after_stall", 2'b10, 1'b1, 8'b0010_1110, 1'b0, 6, 1'b1);

    // Reset during the third ITER cycle discards the operation
    set_req(0, 8'h6E, 4'h7); req_valid = 2'b01;
    #1;
    chk("mid gnt", 32'(req_ready), 32'(2'b01));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("mid rst rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("mid rst req_ready", 32'(req_ready), 32'(2'b00));
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("mid no response", 32'(seen), 32'(1'b0));

    // Fresh op, pointer must be back at requester 0
    set_req(0, 8'h0D, 4'h5);
    set_req(1, 8'h07, 4'h3);
    req_valid = 2'b11;
    run("post_rst", 2'b01, 1'b0, 8'b0011_0010, 1'b0, 6, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/div_nr_sched.md
Name: div_nr_sched

Overview:
- Shares one iterative 8/4 nonrestoring divide datapath between NREQ requesters.
- Provides a per-requester valid/ready request handshake and a single response channel tagged with the requester id.
- Arbitrates round-robin and sequences the divide at one quotient bit per clock.
- Screens out divide-by-zero and quotient-overflow operands before iterating.
- Result packing: rslt[7:4] = remainder, rslt[3:0] = quotient.

Parameters:
NREQ, 2, number of requesters (2..4)
IDW, 1, width of rsp_id (must satisfy 2**IDW >= NREQ)

Ports:
clk  input  1  clock; all state changes on its rising edge
rst_n  input  1  reset; synchronous, active-low
req_valid  input  NREQ  requester i has an operation pending
req_a  input  8*NREQ  dividend of requester i, bits [8i+7:8i]
req_b  input  4*NREQ  divisor of requester i, bits [4i+3:4i]
req_ready  output  NREQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts the response
rsp_id  output  IDW  index of the requester being answered
rslt  output  8  {remainder[3:0], quotient[3:0]}
err  output  1  1 = divide-by-zero or quotient overflow; rslt is 8'h00 when err = 1

Behaviour:
- Reset: rst_n sampled low at a clock edge sets the following.
  - state = IDLE; rr pointer = 0 (requester 0 has top priority).
  - rsp_valid, rsp_id, rslt and err all 0; iteration counter 0.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. Holding rst_n low keeps req_ready = 0.
- States and transitions:
  - IDLE → ITER on accept; IDLE → DONE on accept of an error operand.
  - ITER (4 cycles) → FIX → DONE.
  - DONE → IDLE on rsp_ready.
- Arbitration (IDLE only):
  - req_ready is combinational from req_valid and the rr pointer.
  - It is the one-hot of the first valid requester found at or after the pointer, wrapping.
  - req_ready is 0 in every other state.
  - On accept, the pointer becomes (granted index + 1) mod NREQ.
  - A requester may drop req_valid while not granted; no state changes.
- On accept, the block latches the operands a and b and the requester id.
- Error screen at accept:
  - b == 0 → divide-by-zero.
  - a[7:4] >= b → the quotient does not fit in 4 bits (overflow).
  - Either case goes straight to DONE with err = 1 and rslt = 8'h00.
- Datapath on accept: R = {2'b00, a[7:4]} (6-bit signed partial remainder); Q = a[3:0].
- Each ITER cycle:
  - If R >= 0: R = 2R + Q[3] - b. Otherwise: R = 2R + Q[3] + b.
  - Then Q = {Q[2:0], ~R_new[5]}.
  - The counter runs 0..3; leave ITER after count 3.
- FIX: if R < 0 then R = R + b. Then rslt = {R[3:0], Q}, err = 0.
- Latency, with accept at edge T:
  - Normal path: ITER at T+1..T+4, FIX at T+5, rsp_valid = 1 from T+6.
  - Error path: rsp_valid = 1 from T+1.
- Response handshake:
  - rsp_valid, rsp_id, rslt and err are registered and held stable until rsp_valid & rsp_ready.
  - On that edge rsp_valid drops and the state returns to IDLE.
  - Earliest next accept is the following cycle, so there is no back-to-back accept in the same cycle as a response.
  - rsp_ready is ignored when rsp_valid = 0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...

Test Plan:
- Requester 0 sends a = 8'h07, b = 4'h3, rsp_ready tied to 1 → req_ready[0] = 1 at T, rsp_valid = 1 exactly at T+6, rsp_id = 0, rslt = 8'b0001_0010, err = 0.
- Directed vectors through requester 1 → rsp_id = 1 and err = 0 for each:
  - 8'h3C / 7 → rslt = 8'b0100_1000
  - 8'h52 / 6 → 8'b0100_1101
  - 8'h64 / 7 → 8'b0010_1110
  - 8'h6E / 7 → 8'b0101_1111
- Error cases:
  - 8'h80 / 3 (overflow) → rsp_valid at T+1, err = 1, rslt = 8'h00.
  - 8'h15 / 0 → err = 1, rslt = 8'h00.
- Both requesters held valid for 4 operations → grant order 0,1,0,1.
  - Each response carries the matching rsp_id.
  - req_ready = 0 throughout ITER, FIX and DONE.
- rsp_ready held 0 for 5 cycles after rsp_valid → rslt, rsp_id and err stay stable and no new accept occurs. Raising rsp_ready → IDLE the next cycle, then the next grant.
- rst_n driven low during the 3rd ITER cycle → state IDLE and rsp_valid = 0 after that edge, and no response appears. A fresh 8'h0D / 5 afterwards → rslt = 8'b0011_0010, with requester 0 granted first.
